// File: rtl/sips4_prog_loader.sv
// SIPS4 program loader: receives a framed byte stream, assembles 16-bit words,
// writes them to instruction memory and holds the core until the checksum passes.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle pulse that begins or restarts a load
//   rx_data/valid/ready   8-bit byte stream with valid/ready handshake
//   imem_waddr/wdata/wen  instruction memory write port
//   cpu_hold              core stall
//   load_done/load_err    result of the last load
module sips4_prog_loader #(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned DATA_W    = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              imem_wen,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [7:0]  MAX_N = 8'(1 << ADDR_W);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_CNT, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [7:0]          hi_q, hi_d;
   logic [7:0]          chk_q, chk_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                acc;

   // start wins over a byte offered in the same cycle, so refuse it
   assign rx_ready = !start &&
                     (state_q inside {S_HDR, S_CNT, S_HI, S_LO, S_CHK});
   assign acc      = rx_valid && rx_ready;

   assign imem_waddr = addr_q;
   assign imem_wdata = wdata_q;
   assign imem_wen   = (state_q == S_WR);
   assign cpu_hold   = hold_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hi_d    = hi_q;
      chk_d   = chk_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;
      if (start) begin
         state_d = S_HDR;
         hold_d  = 1'b1;
         done_d  = 1'b0;
         err_d   = 1'b0;
         addr_d  = '0;
         chk_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_HDR: if (acc && rx_data == SYNC_BYTE) state_d = S_CNT;
            S_CNT: if (acc) begin
               if (rx_data != 8'd0 && rx_data <= MAX_N) begin
                  n_d     = rx_data[CNT_W-1:0];
                  state_d = S_HI;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end
            end
            S_HI: if (acc) begin
               hi_d    = rx_data;
               chk_d   = chk_q ^ rx_data;
               state_d = S_LO;
            end
            S_LO: if (acc) begin
               chk_d   = chk_q ^ rx_data;
               wdata_d = DATA_W'({hi_q, rx_data});
               state_d = S_WR;
            end
            S_WR: begin
               addr_d  = addr_q + 1'b1;
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_d == n_q) ? S_CHK : S_HI;
            end
            S_CHK: if (acc) begin
               if (rx_data == chk_q) begin
                  hold_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         hi_q    <= '0;
         chk_q   <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hi_q    <= hi_d;
         chk_q   <= chk_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_sips4_prog_loader.sv
// Self-checking bench for sips4_prog_loader: directed frames plus random frames
// compared against a frame-level model of the expected writes and status.
module tb_sips4_prog_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [3:0]  imem_waddr;
   logic [15:0] imem_wdata;
   logic        imem_wen;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [19:0] got[$];

   sips4_prog_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .imem_wen   (imem_wen),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #10 clk = ~clk;

   always @(posedge clk) if (imem_wen) got.push_back({imem_waddr, imem_wdata});

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      got.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
      rx_data  = $urandom;
   endtask

   function automatic logic [7:0] garbage();
      logic [7:0] g;
      do g = 8'($urandom); while (g == 8'hA5);
      return g;
   endfunction

   // kind: 0 good, 1 bad checksum, 2 bad count
   function automatic bq_t mk_frame(input int n, input int kind, input int ng);
      bq_t f;
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      for (int i = 0; i < ng; i++) f.push_back(garbage());
      f.push_back(8'hA5);
      if (kind == 2) begin
         b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
         f.push_back(b);
         return f;
      end
      f.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) begin
         b = 8'($urandom);
         f.push_back(b);
         x ^= b;
      end
      if (kind == 1) x ^= 8'($urandom_range(1, 255));
      f.push_back(x);
      return f;
   endfunction

   task automatic run_frame(input bq_t f, input string tag, input bit do_start);
      logic [19:0] exp[$];
      logic [7:0]  x = 8'h00;
      int          i = 0;
      int          n;
      bit          e_done = 1'b0;
      while (i < f.size() && f[i] != 8'hA5) i++;
      n = int'(f[i+1]);
      if (n >= 1 && n <= 16) begin
         for (int w = 0; w < n; w++) begin
            exp.push_back({4'(w), f[i+2+2*w], f[i+3+2*w]});
            x ^= f[i+2+2*w] ^ f[i+3+2*w];
         end
         e_done = (f[i+2+2*n] == x);
      end
      if (do_start) begin
         pulse_start();
         @(negedge clk);
         check({tag, "_hold_loading"}, {31'b0, cpu_hold}, 32'd1);
         check({tag, "_done_cleared"}, {31'b0, load_done}, 32'd0);
      end
      foreach (f[k]) send_byte(f[k]);
      repeat (4) @(negedge clk);
      check({tag, "_nwrites"}, got.size(), exp.size());
      foreach (exp[k]) if (k < got.size())
         check({tag, "_write"}, {12'b0, got[k]}, {12'b0, exp[k]});
      check({tag, "_done"}, {31'b0, load_done}, {31'b0, e_done});
      check({tag, "_err"}, {31'b0, load_err}, {31'b0, !e_done});
      check({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, !e_done});
      check({tag, "_ready_low"}, {31'b0, rx_ready}, 32'd0);
   endtask

   initial begin
      bq_t f;
      #35 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'b0, rx_ready}, 32'd0);
      check("rst_wen", {31'b0, imem_wen}, 32'd0);
      check("rst_hold", {31'b0, cpu_hold}, 32'd0);
      check("rst_done", {31'b0, load_done}, 32'd0);
      check("rst_err", {31'b0, load_err}, 32'd0);
      check("rst_addr", {28'b0, imem_waddr}, 32'd0);
      check("rst_wdata", {16'b0, imem_wdata}, 32'd0);

      f = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_frame(f, "good2", 1'b1);
      f = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      run_frame(f, "badchk", 1'b1);
      f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h01, 8'h81};
      run_frame(f, "garbage", 1'b1);
      f = '{8'hA5, 8'h00};
      run_frame(f, "cnt00", 1'b1);
      f = '{8'hA5, 8'h11};
      run_frame(f, "cnt11", 1'b1);
      f = '{8'hA5, 8'h10};
      for (int w = 0; w < 16; w++) begin
         f.push_back(8'h00);
         f.push_back(8'(w));
      end
      f.push_back(8'h00);
      run_frame(f, "n16", 1'b1);

      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h12);
      @(negedge clk);
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h34;
      #1 check("mid_start_ready", {31'b0, rx_ready}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      check("mid_start_addr", {28'b0, imem_waddr}, 32'd0);
      check("mid_start_hdr_ready", {31'b0, rx_ready}, 32'd1);
      check("mid_start_nowrite", got.size(), 32'd0);
      f = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h51};
      run_frame(f, "after_restart", 1'b0);

      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h77);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", {31'b0, rx_ready}, 32'd0);
      check("arst_hold", {31'b0, cpu_hold}, 32'd0);
      check("arst_done", {31'b0, load_done}, 32'd0);
      check("arst_err", {31'b0, load_err}, 32'd0);
      check("arst_wen", {31'b0, imem_wen}, 32'd0);
      check("arst_wdata", {16'b0, imem_wdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 30; t++) begin
         int k = $urandom_range(0, 9);
         int kind = (k < 6) ? 0 : (k < 8) ? 1 : 2;
         f = mk_frame($urandom_range(1, 16), kind, $urandom_range(0, 3));
         run_frame(f, $sformatf("rnd%0d", t), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
